// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NCH FWFT byte
// sources, with a per-grant burst limit and an optional channel header byte.
module uart_tx_arbiter #(
   parameter int NCH       = 4,
   parameter int MAX_BURST = 16,
   parameter bit HDR_EN    = 1'b1
) (
   input  logic             CLK288MHZ,
   input  logic             resetN,
   input  logic [NCH-1:0]   chanEn,
   input  logic [NCH-1:0]   reqNE,
   input  logic [8*NCH-1:0] reqData,
   output logic [NCH-1:0]   reqPop,
   output logic [8:0]       txData,
   output logic             txValid,
   input  logic             txReadEn,
   output logic [2:0]       grantId,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_POST} state_t;

   state_t         state_q;
   logic [2:0]     grant_q;
   logic [2:0]     ptr_q;
   logic [7:0]     cnt_q;
   logic           rd_prev_q;
   logic [NCH-1:0] pop_q;

   logic [NCH-1:0] eligible;
   logic           cand_vld;
   logic [2:0]     cand_id;
   logic [7:0]     head;
   logic           head_ne;
   logic [NCH-1:0] grant_oh;
   logic [2:0]     ptr_nxt;
   logic           evt;

   assign eligible = reqNE & chanEn;

   // Descending scan so the lowest rotation offset from the pointer wins.
   always_comb begin
      cand_vld = 1'b0;
      cand_id  = '0;
      for (int k = NCH-1; k >= 0; k--) begin
         for (int i = 0; i < NCH; i++) begin
            if (eligible[i] && ((int'(ptr_q) + k) % NCH) == i) begin
               cand_vld = 1'b1;
               cand_id  = 3'(i);
            end
         end
      end
   end

   always_comb begin
      head     = '0;
      head_ne  = 1'b0;
      grant_oh = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant_q == 3'(i)) begin
            head        = reqData[8*i +: 8];
            head_ne     = reqNE[i];
            grant_oh[i] = 1'b1;
         end
      end
   end

   assign ptr_nxt = (grant_q == 3'(NCH-1)) ? 3'd0 : grant_q + 3'd1;

   assign txValid = (state_q == S_HDR) || ((state_q == S_DATA) && head_ne);

   always_comb begin
      case (state_q)
         S_HDR:   txData = {1'b0, 4'hA, 1'b0, grant_q};
         S_DATA:  txData = {1'b0, head};
         default: txData = '0;
      endcase
   end

   // A held-high readEn is one event; an edge with nothing presented is dropped.
   assign evt = txReadEn && !rd_prev_q && txValid;

   always_ff @(posedge CLK288MHZ or negedge resetN) begin
      if (!resetN) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         rd_prev_q <= 1'b0;
         pop_q     <= '0;
      end else begin
         rd_prev_q <= txReadEn;
         pop_q     <= '0;
         case (state_q)
            S_IDLE: begin
               if (cand_vld) begin
                  grant_q <= cand_id;
                  cnt_q   <= '0;
                  state_q <= HDR_EN ? S_HDR : S_DATA;
               end
            end
            S_HDR: begin
               if (evt) state_q <= S_POST;
            end
            S_DATA: begin
               if (evt) begin
                  pop_q   <= grant_oh;
                  cnt_q   <= cnt_q + 8'd1;
                  state_q <= S_POST;
               end else if (!head_ne) begin
                  ptr_q   <= ptr_nxt;
                  state_q <= S_IDLE;
               end
            end
            // One cycle for the pop to land before the FIFO head is trusted again.
            S_POST: begin
               if (cnt_q == 8'(MAX_BURST)) begin
                  ptr_q   <= ptr_nxt;
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_DATA;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign reqPop  = pop_q;
   assign grantId = grant_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: FWFT source models, a transmitter model
// that consumes frames and checks them against a queue of expected bytes.
module tb_uart_tx_arbiter;

   localparam int NCH = 4;
   localparam int BIG = 1000000;

   logic             CLK288MHZ = 1'b0;
   logic             resetN;
   logic [NCH-1:0]   chanEn;
   logic [NCH-1:0]   reqNE;
   logic [8*NCH-1:0] reqData;
   logic [NCH-1:0]   reqPop;
   logic [8:0]       txData;
   logic             txValid;
   logic             txReadEn;
   logic [2:0]       grantId;
   logic             busy;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];
   logic [7:0] mem [NCH][256];
   int wp[NCH]      = '{default: 0};
   int rp[NCH]      = '{default: 0};
   int pop_cnt[NCH] = '{default: 0};
   int frame_limit  = BIG;
   int taken        = 0;
   int hold_len     = 1;

   uart_tx_arbiter #(.NCH(NCH), .MAX_BURST(16), .HDR_EN(1'b1)) dut (
      .CLK288MHZ (CLK288MHZ),
      .resetN    (resetN),
      .chanEn    (chanEn),
      .reqNE     (reqNE),
      .reqData   (reqData),
      .reqPop    (reqPop),
      .txData    (txData),
      .txValid   (txValid),
      .txReadEn  (txReadEn),
      .grantId   (grantId),
      .busy      (busy)
   );

   always #5 CLK288MHZ = ~CLK288MHZ;

   for (genvar g = 0; g < NCH; g++) begin : g_src
      assign reqNE[g]          = (wp[g] != rp[g]);
      assign reqData[8*g +: 8] = mem[g][rp[g][7:0]];
   end

   always @(posedge CLK288MHZ) begin
      for (int i = 0; i < NCH; i++) begin
         if (reqPop[i] && (wp[i] != rp[i])) begin
            rp[i]      <= rp[i] + 1;
            pop_cnt[i] <= pop_cnt[i] + 1;
         end
      end
   end

   // Transmitter model and monitor.
   initial begin
      int hold_left;
      int gap_left;
      logic lv;
      logic [8:0] ld;
      logic [8:0] e;
      hold_left = 0;
      gap_left  = 0;
      lv        = 1'b0;
      ld        = '0;
      txReadEn  = 1'b0;
      forever begin
         @(negedge CLK288MHZ);
         if (resetN && txValid && lv && !txReadEn) begin
            checks++;
            if (txData !== ld) begin
               errors++;
               $display("FAIL txData_stable got=%03h exp=%03h t=%0t", txData, ld, $time);
            end
         end
         for (int i = 0; i < NCH; i++) begin
            if (reqPop[i]) begin
               checks++;
               if (wp[i] == rp[i]) begin
                  errors++;
                  $display("FAIL pop_on_empty ch=%0d got=pop exp=no_pop t=%0t", i, $time);
               end
            end
         end
         lv = txValid;
         ld = txData;
         if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) begin
               txReadEn = 1'b0;
               gap_left = 2;
            end
         end else if (gap_left > 0) begin
            gap_left--;
         end else if (resetN && txValid && taken < frame_limit) begin
            taken++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame_unexpected got=%03h exp=none t=%0t", txData, $time);
            end else begin
               e = exp_q.pop_front();
               if (txData !== e) begin
                  errors++;
                  $display("FAIL frame_data got=%03h exp=%03h t=%0t", txData, e, $time);
               end
            end
            txReadEn  = 1'b1;
            hold_left = hold_len;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic load(input int ch, input logic [7:0] b);
      mem[ch][wp[ch][7:0]] = b;
      wp[ch] = wp[ch] + 1;
   endtask

   task automatic push(input logic [8:0] b);
      exp_q.push_back(b);
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (n < 3000 && !(exp_q.size() == 0 && !busy && !txReadEn)) begin
         @(negedge CLK288MHZ);
         n++;
      end
      chk({nm, "_timeout"}, (n >= 3000) ? 1 : 0, 0);
      repeat (4) @(negedge CLK288MHZ);
   endtask

   task automatic do_reset();
      @(negedge CLK288MHZ);
      resetN = 1'b0;
      repeat (3) @(negedge CLK288MHZ);
      resetN = 1'b1;
      @(negedge CLK288MHZ);
   endtask

   initial begin
      int p0, p1, p2, p3, n;
      resetN = 1'b0;
      chanEn = '1;
      repeat (3) @(negedge CLK288MHZ);
      chk("rst_txValid", int'(txValid), 0);
      chk("rst_txData", int'(txData), 0);
      chk("rst_reqPop", int'(reqPop), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_grantId", int'(grantId), 0);
      resetN = 1'b1;
      repeat (2) @(negedge CLK288MHZ);

      // Single channel, header then three bytes.
      push(9'h0A0); push(9'h011); push(9'h022); push(9'h033);
      load(0, 8'h11); load(0, 8'h22); load(0, 8'h33);
      wait_done("t1");
      chk("t1_pops_ch0", pop_cnt[0], 3);
      chk("t1_busy", int'(busy), 0);

      // Pointer now at 1: ch1 goes before ch0.
      push(9'h0A1); push(9'h066); push(9'h0A0); push(9'h044);
      load(0, 8'h44); load(1, 8'h66);
      wait_done("t1b");
      chk("t1b_pops_ch0", pop_cnt[0], 4);
      chk("t1b_pops_ch1", pop_cnt[1], 1);

      // Disabled ch1 is skipped although the pointer favours it.
      chanEn = 4'b1101;
      push(9'h0A3); push(9'h0B3);
      load(1, 8'hB1); load(3, 8'hB3);
      wait_done("t5");
      chk("t5_pops_ch1", pop_cnt[1], 1);
      chk("t5_pops_ch3", pop_cnt[3], 1);
      chk("t5_ch1_pending", int'(reqNE[1]), 1);
      push(9'h0A1); push(9'h0B1);
      chanEn = 4'b1111;
      wait_done("t5b");
      chk("t5b_pops_ch1", pop_cnt[1], 2);

      // readEn held high for 5 cycles per frame.
      hold_len = 5;
      push(9'h0A3); push(9'h077);
      load(3, 8'h77);
      wait_done("t3");
      chk("t3_pops_ch3", pop_cnt[3], 2);
      hold_len = 1;

      // Stalled transmitter: header must sit still.
      frame_limit = taken;
      load(1, 8'h5A);
      repeat (10) @(negedge CLK288MHZ);
      chk("t4_busy", int'(busy), 1);
      chk("t4_grantId", int'(grantId), 1);
      chk("t4_txValid", int'(txValid), 1);
      chk("t4_txData", int'(txData), 9'h0A1);
      push(9'h0A1); push(9'h05A);
      frame_limit = BIG;
      wait_done("t4");
      chk("t4_pops_ch1", pop_cnt[1], 3);

      // Two channels of 20 bytes with a 16-byte burst limit.
      do_reset();
      p0 = pop_cnt[0];
      p2 = pop_cnt[2];
      push(9'h0A0);
      for (int i = 0; i < 16; i++) push(9'(i));
      push(9'h0A2);
      for (int i = 0; i < 16; i++) push(9'(8'h80 + i));
      push(9'h0A0);
      for (int i = 16; i < 20; i++) push(9'(i));
      push(9'h0A2);
      for (int i = 16; i < 20; i++) push(9'(8'h80 + i));
      for (int i = 0; i < 20; i++) begin
         load(0, 8'(i));
         load(2, 8'(8'h80 + i));
      end
      wait_done("t2");
      chk("t2_pops_ch0", pop_cnt[0] - p0, 20);
      chk("t2_pops_ch2", pop_cnt[2] - p2, 20);
      chk("t2_ch0_empty", int'(reqNE[0]), 0);
      chk("t2_ch2_empty", int'(reqNE[2]), 0);

      // Reset while 0x55 is presented but not yet consumed.
      do_reset();
      p0 = pop_cnt[0];
      frame_limit = taken + 1;
      push(9'h0A0);
      load(0, 8'h55);
      n = 0;
      while (n < 200 && !(txValid && txData == 9'h055 && !txReadEn)) begin
         @(negedge CLK288MHZ);
         n++;
      end
      chk("t6_presenting_55", (n >= 200) ? 1 : 0, 0);
      repeat (3) @(negedge CLK288MHZ);
      #2;
      resetN = 1'b0;
      #1;
      chk("t6_async_txValid", int'(txValid), 0);
      chk("t6_async_txData", int'(txData), 0);
      chk("t6_async_busy", int'(busy), 0);
      chk("t6_async_reqPop", int'(reqPop), 0);
      chk("t6_pops_before", pop_cnt[0] - p0, 0);
      @(negedge CLK288MHZ);
      push(9'h0A0); push(9'h055);
      frame_limit = BIG;
      resetN = 1'b1;
      wait_done("t6");
      chk("t6_pops_ch0", pop_cnt[0] - p0, 1);
      chk("t6_ch0_empty", int'(reqNE[0]), 0);

      p1 = exp_q.size();
      chk("end_exp_empty", p1, 0);
      p3 = pop_cnt[3];
      chk("end_pops_ch3", p3, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NCH independent byte sources, each presented as a first-word-fall-through FIFO read port.
- Grants channels round-robin with a per-grant burst limit and, optionally, inserts a one-byte channel header whenever ownership changes.
- Sits between the per-source FIFOs and the transmitter: drives the transmitter's data/not-empty inputs and consumes its read-enable.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- MAX_BURST, 16, maximum data bytes sent per grant before rotating (1..255).
- HDR_EN, 1, 1 = send header byte {4'hA, 1'b0, id[2:0]} before the first data byte of each grant; 0 = no header.

Ports:
- CLK288MHZ  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- chanEn  in  NCH  per-channel enable mask; a disabled channel is never newly granted.
- reqNE  in  NCH  per-channel FIFO not-empty.
- reqData  in  8*NCH  per-channel FIFO head byte; channel i occupies bits [8i+7:8i].
- reqPop  out  NCH  one-cycle pop pulse to channel i's FIFO.
- txData  out  9  byte to the transmitter; bit 8 is always 0.
- txValid  out  1  drives the transmitter's fifoNE input.
- txReadEn  in  1  transmitter's readEn; may stay high for more than one cycle.
- grantId  out  3  currently granted channel; meaningful while busy=1.
- busy  out  1  a grant is held.

Behaviour:
- Reset while resetN=0, all outputs: txValid=0, txData=0, reqPop=0, grantId=0, busy=0. The round-robin pointer and burst counter clear to 0.
- Reset mid-transfer: the grant is abandoned with no pop, so the in-flight byte is re-sent after reset.
- Consumption event:
  - A consumption event is the rising edge of txReadEn, taken from a registered previous value.
  - A continuous high level counts as exactly one event.
  - An edge while txValid=0 is ignored.
- States:
  - IDLE: busy=0, txValid=0. Pick the first i in rotation order starting at the pointer with reqNE[i]&chanEn[i].
    - A candidate exists: latch grantId=i, clear the burst count, set busy=1.
    - HDR_EN=1: go to HDR. HDR_EN=0: go to DATA.
    - No candidate: stay in IDLE.
  - HDR: txData=header, txValid=1. On a consumption event go to DATA; no pop is issued.
  - DATA, presenting:
    - txData=reqData[grantId], txValid=reqNE[grantId].
    - On a consumption event: pulse reqPop[grantId] for exactly 1 cycle and increment the burst count.
  - DATA, after the pop (next cycle):
    - Release the grant when the burst count reaches MAX_BURST, or when reqNE[grantId]=0 after the pop has settled.
    - Release means: pointer = grantId+1 (mod NCH), then IDLE.
    - Otherwise stay in DATA.
- Latency:
  - IDLE to txValid=1: 1 cycle after the request is seen.
  - Consumption edge to reqPop: same cycle as the edge detection, i.e. 1 cycle after txReadEn rises.
  - Next txData/txValid is valid 2 cycles after the edge. This is well inside the transmitter's 32-tick stop interval, so back-to-back bytes are not delayed.
- Data stability:
  - txData must not change while txValid=1 and no consumption event has occurred; the transmitter samples bits live across the frame.
  - Sources are FWFT and must not retract reqNE without a pop; the arbiter relies on this.
- chanEn clearing for the granted channel does not revoke the grant; it only blocks re-grant.
- Simultaneous events:
  - A new request arriving in the cycle of a release waits one IDLE cycle.
  - A consumption event on the last burst byte pops and releases in the same sequence.
- A single active channel may be re-granted immediately after release; with HDR_EN=1 it gets a new header.
- NCH=1 is not supported.

Test Plan:
- Single channel 0, HDR_EN=1, 3 bytes 0x11,0x22,0x33 -> txData sequence 0xA0,0x11,0x22,0x33; reqPop[0] pulses exactly 3 times; busy drops after the 3rd pop; pointer=1.
- Channels 0 and 2 each hold 20 bytes, MAX_BURST=16 -> ch0 sends 16, then ch2 sends 16 after header 0xA2, then ch0 sends 4, then ch2 sends 4; no byte lost or duplicated.
- txReadEn held high for 5 cycles on one frame -> exactly one reqPop pulse.
- reqData[grantId] scoreboard while txValid=1 with no event -> txData stable every cycle; assertion never fires.
- chanEn[1]=0 with reqNE[1]=1 and reqNE[3]=1 -> only ch3 is granted; after chanEn[1]=1, ch1 is granted next in rotation.
- resetN pulsed low mid-DATA with ch0 byte 0x55 pending -> outputs zero asynchronously; after release, 0xA0 then 0x55 are re-sent with no extra pop.
